// File: rtl/tj_mon_pkg.sv
// Shared types and constants for the trigger monitor: FSM state encoding,
// readout geometry and the record word index map.
package tj_mon_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    CAPTURED = 2'd1,
    READOUT  = 2'd2
  } state_e;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 5;
  localparam int IDX_W   = 3;

  typedef logic [IDX_W-1:0] idx_t;

  // Word 0 carries the event index, words 1..4 the ciphertext, MSW first.
  localparam idx_t IDX_CNT   = 3'd0;
  localparam idx_t IDX_CT_W3 = 3'd1;
  localparam idx_t IDX_CT_W2 = 3'd2;
  localparam idx_t IDX_CT_W1 = 3'd3;
  localparam idx_t IDX_CT_W0 = 3'd4;
  localparam idx_t IDX_LAST  = idx_t'(N_WORDS - 1);

endpackage

// File: rtl/tj_edge_counter.sv
// Saturating ciphertext event counter plus rising-edge detector on the
// watched trigger line.
module tj_edge_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ct_valid,
  input  logic             trig_in,
  output logic [CNT_W-1:0] evt_count,
  output logic [CNT_W-1:0] cnt_next,
  output logic             rise
);

  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic             trig_q;

  always_comb begin
    evt_count_d = evt_count_q;
    if (ct_valid && (evt_count_q != '1)) begin
      evt_count_d = evt_count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count_q <= '0;
      trig_q      <= 1'b0;
    end else begin
      evt_count_q <= evt_count_d;
      trig_q      <= trig_in;
    end
  end

  // cnt_next lets a capture include the event arriving in the same cycle.
  assign cnt_next  = evt_count_d;
  assign rise      = trig_in & ~trig_q;
  assign evt_count = evt_count_q;

endmodule

// File: rtl/tj_trigger_monitor.sv
// Trigger monitor top: freezes {event index, ciphertext} on the first trigger
// rise and streams the record out as five registered words on request.
module tj_trigger_monitor
  import tj_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ct_valid,
  input  logic [127:0]      ct,
  input  logic              trig_in,
  input  logic              alarm_clr,
  input  logic              rd_req,
  output logic              alarm,
  output logic [CNT_W-1:0]  evt_count,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last
);

  logic [CNT_W-1:0]  cnt_next;
  logic              rise;

  state_e            state_q, state_d;
  idx_t              idx_q, idx_d;
  logic              alarm_q, alarm_d;
  logic [CNT_W-1:0]  cnt_rec_q, cnt_rec_d;
  logic [127:0]      ct_rec_q, ct_rec_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_last_q, rd_last_d;
  logic [WORD_W-1:0] cnt_word;

  tj_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk       (clk),
    .rst       (rst),
    .ct_valid  (ct_valid),
    .trig_in   (trig_in),
    .evt_count (evt_count),
    .cnt_next  (cnt_next),
    .rise      (rise)
  );

  generate
    if (CNT_W >= WORD_W) begin : g_cnt_trunc
      assign cnt_word = cnt_rec_q[WORD_W-1:0];
    end else begin : g_cnt_ext
      assign cnt_word = {{(WORD_W-CNT_W){1'b0}}, cnt_rec_q};
    end
  endgenerate

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    alarm_d    = alarm_q;
    cnt_rec_d  = cnt_rec_q;
    ct_rec_d   = ct_rec_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (rise) begin
          cnt_rec_d = cnt_next;
          ct_rec_d  = ct_valid ? ct : '0;
          alarm_d   = 1'b1;
          state_d   = CAPTURED;
        end
      end
      CAPTURED: begin
        if (rd_req) begin
          state_d    = READOUT;
          idx_d      = IDX_CNT;
          rd_valid_d = 1'b1;
        end else if (alarm_clr) begin
          alarm_d = 1'b0;
          state_d = ARMED;
        end
      end
      READOUT: begin
        // idx_q is the word on rd_data this cycle; the stream ends after the last.
        if (idx_q == IDX_LAST) begin
          state_d = CAPTURED;
        end else begin
          idx_d      = idx_q + idx_t'(1);
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_valid_d) begin
      unique case (idx_d)
        IDX_CNT:   rd_data_d = cnt_word;
        IDX_CT_W3: rd_data_d = ct_rec_q[127:96];
        IDX_CT_W2: rd_data_d = ct_rec_q[95:64];
        IDX_CT_W1: rd_data_d = ct_rec_q[63:32];
        IDX_CT_W0: rd_data_d = ct_rec_q[31:0];
        default:   rd_data_d = '0;
      endcase
    end
    rd_last_d = rd_valid_d && (idx_d == IDX_LAST);
  end

  // NOTE: the record registers are reset too; they are observable through
  // readout, so a stale record must never survive a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARMED;
      idx_q      <= IDX_CNT;
      alarm_q    <= 1'b0;
      cnt_rec_q  <= '0;
      ct_rec_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      alarm_q    <= alarm_d;
      cnt_rec_q  <= cnt_rec_d;
      ct_rec_q   <= ct_rec_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign alarm    = alarm_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_tj_trigger_monitor.sv
// Self-checking bench for tj_trigger_monitor: directed table, corner-case
// sequences and random stimulus against a transaction-level reference model.
module tb_tj_trigger_monitor;

  localparam logic [127:0] CT_A = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst, ct_valid, trig_in, alarm_clr, rd_req;
  logic [127:0] ct;

  logic         alarm, rd_valid, rd_last;
  logic [31:0]  evt_count, rd_data;
  logic         alarm4, rd_valid4, rd_last4;
  logic [3:0]   evt_count4;
  logic [31:0]  rd_data4;

  always #5 clk = ~clk;

  tj_trigger_monitor #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ct_valid(ct_valid), .ct(ct), .trig_in(trig_in),
    .alarm_clr(alarm_clr), .rd_req(rd_req), .alarm(alarm), .evt_count(evt_count),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last)
  );

  tj_trigger_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ct_valid(ct_valid), .ct(ct), .trig_in(trig_in),
    .alarm_clr(alarm_clr), .rd_req(rd_req), .alarm(alarm4), .evt_count(evt_count4),
    .rd_valid(rd_valid4), .rd_data(rd_data4), .rd_last(rd_last4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an unbounded event count, the alarm doubling as the
  // "record frozen" flag, and a queue of record word numbers still to stream.
  longint unsigned m_n;
  logic            m_prev;
  logic            m_alarm;
  longint unsigned m_rec_n;
  logic [127:0]    m_rec_ct;
  int              m_q[$];

  function automatic longint unsigned sat(input longint unsigned n, input int w);
    longint unsigned mx = (64'd1 << w) - 64'd1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [63:0] exp_word(input int k, input int w);
    logic [127:0] c = m_rec_ct;
    if (k == 0) return sat(m_rec_n, w) & 64'hffff_ffff;
    return 64'(c[127-32*(k-1) -: 32]);
  endfunction

  task automatic model_step();
    bit busy = (m_q.size() > 0);
    bit rise = trig_in && !m_prev;
    if (rst) begin
      m_n = 0; m_prev = 1'b0; m_alarm = 1'b0; m_rec_n = 0; m_rec_ct = '0;
      m_q.delete();
    end else begin
      if (busy) void'(m_q.pop_front());
      else if (m_alarm) begin
        if (rd_req) for (int k = 0; k < 5; k++) m_q.push_back(k);
        else if (alarm_clr) m_alarm = 1'b0;
      end else if (rise) begin
        m_alarm  = 1'b1;
        m_rec_n  = m_n + 64'(ct_valid);
        m_rec_ct = ct_valid ? ct : '0;
      end
      m_n    = m_n + 64'(ct_valid);
      m_prev = trig_in;
    end
  endtask

  task automatic model_check();
    bit          v  = (m_q.size() > 0);
    logic [63:0] d  = v ? exp_word(m_q[0], 32) : 64'd0;
    logic [63:0] d4 = v ? exp_word(m_q[0], 4) : 64'd0;
    bit          l  = v && (m_q[0] == 4);
    check("m_evt_count",   64'(evt_count),  sat(m_n, 32));
    check("m_evt_count_4", 64'(evt_count4), sat(m_n, 4));
    check("m_alarm",       64'(alarm),      64'(m_alarm));
    check("m_alarm_4",     64'(alarm4),     64'(m_alarm));
    check("m_rd_valid",    64'(rd_valid),   64'(v));
    check("m_rd_valid_4",  64'(rd_valid4),  64'(v));
    check("m_rd_data",     64'(rd_data),    d);
    check("m_rd_data_4",   64'(rd_data4),   d4);
    check("m_rd_last",     64'(rd_last),    64'(l));
    check("m_rd_last_4",   64'(rd_last4),   64'(l));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic set_in(input logic r, input logic cv, input logic tr, input logic clr,
                        input logic req, input logic [127:0] c);
    rst = r; ct_valid = cv; trig_in = tr; alarm_clr = clr; rd_req = req; ct = c;
  endtask

  typedef struct {
    logic         rst, cv, trig, clr, req;
    logic [127:0] ct;
    logic [31:0]  e_evt;
    logic         e_alarm, e_rv;
    logic [31:0]  e_data;
    logic         e_last;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic cv, input logic tr, input logic clr,
                     input logic req, input logic [127:0] c, input logic [31:0] e_evt,
                     input logic e_alarm, input logic e_rv, input logic [31:0] e_data,
                     input logic e_last);
    vec_t v;
    v.rst = r; v.cv = cv; v.trig = tr; v.clr = clr; v.req = req; v.ct = c;
    v.e_evt = e_evt; v.e_alarm = e_alarm; v.e_rv = e_rv; v.e_data = e_data; v.e_last = e_last;
    tbl.push_back(v);
  endtask

  task automatic read_record(input logic [31:0] e_cnt, input logic [127:0] e_ct);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("rd_word0_valid", 64'(rd_valid), 64'd1);
    check("rd_word0_data",  64'(rd_data),  64'(e_cnt));
    for (int k = 1; k < 5; k++) begin
      tick();
      check("rd_word_valid", 64'(rd_valid), 64'd1);
      check("rd_word_data",  64'(rd_data),  64'(e_ct[127-32*(k-1) -: 32]));
      check("rd_word_last",  64'(rd_last),  64'(k == 4));
    end
    tick();
    check("rd_end_valid", 64'(rd_valid), 64'd0);
  endtask

  initial begin
    logic [31:0]  exp_cnt;
    logic [127:0] ct_d;

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    m_n = 0; m_prev = 1'b0; m_alarm = 1'b0; m_rec_n = 0; m_rec_ct = '0;

    // Directed table: reset, 10 events with rd_req in ARMED, then capture and readout.
    add(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(0, 1, 0, 0, logic'(i % 2), '0, 32'(i), 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 0, 0, '0, 32'(i), 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, CT_A, 8, 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, '0, 8, 1, 1, 32'd8, 0);
    add(0, 0, 1, 0, 0, '0, 8, 1, 1, 32'h00112233, 0);
    add(0, 0, 1, 0, 0, '0, 8, 1, 1, 32'h44556677, 0);
    add(0, 0, 1, 0, 0, '0, 8, 1, 1, 32'h8899aabb, 0);
    add(0, 0, 1, 0, 0, '0, 8, 1, 1, 32'hccddeeff, 1);
    add(0, 0, 1, 0, 0, '0, 8, 1, 0, 32'd0, 0);

    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].cv, tbl[i].trig, tbl[i].clr, tbl[i].req, tbl[i].ct);
      tick();
      check("tbl_evt_count", 64'(evt_count), 64'(tbl[i].e_evt));
      check("tbl_alarm",     64'(alarm),     64'(tbl[i].e_alarm));
      check("tbl_rd_valid",  64'(rd_valid),  64'(tbl[i].e_rv));
      check("tbl_rd_data",   64'(rd_data),   64'(tbl[i].e_data));
      check("tbl_rd_last",   64'(rd_last),   64'(tbl[i].e_last));
    end

    // Trigger held high, then a second rise while CAPTURED: record must not move.
    for (int i = 0; i < 20; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    check("sat_evt_count_4", 64'(evt_count4), 64'd15);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ~CT_A);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    read_record(32'd8, CT_A);

    // Clear and re-arm, then a rise with no valid ciphertext: ct_rec is zero.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick();
    check("clr_alarm", 64'(alarm), 64'd0);
    exp_cnt = 32'(m_n);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CT_A);
    tick();
    check("rearm_alarm", 64'(alarm), 64'd1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    read_record(exp_cnt, '0);

    // Clear again, then a rise with a same-cycle valid event.
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    ct_d    = {$urandom, $urandom, $urandom, $urandom};
    exp_cnt = 32'(m_n + 1);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ct_d);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    read_record(exp_cnt, ct_d);

    // rd_req together with alarm_clr: readout wins; alarm_clr during readout ignored.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    tick();
    check("req_clr_rd_valid", 64'(rd_valid), 64'd1);
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("req_clr_alarm_kept", 64'(alarm), 64'd1);
    check("req_clr_done", 64'(rd_valid), 64'd0);
    alarm_clr = 1'b0;

    // Reset while readout word 2 is on the bus.
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    check("pre_rst_word2", 64'(rd_data), 64'(ct_d[95:64]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_alarm", 64'(alarm), 64'd0);
    check("rst_evt_count", 64'(evt_count), 64'd0);
    trig_in = 1'b1;
    tick();
    check("rst_armed_capture", 64'(alarm), 64'd1);
    trig_in = 1'b0;

    // Random stimulus against the reference model.
    for (int i = 0; i < 4000; i++) begin
      set_in(logic'($urandom_range(0, 299) == 0), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 7) < 3), logic'($urandom_range(0, 15) == 0),
             logic'($urandom_range(0, 7) == 0), {$urandom, $urandom, $urandom, $urandom});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
